// File: rtl/uart_rx_frame_if.sv
// Parallel side of the UART receiver plus the serial line it listens to.
// The slave modport is the receiver; the master modport is whoever drives the line and consumes bytes.
interface uart_rx_frame_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 rx;
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output rx,
        input  data,
        input  valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rx,
        output data,
        output valid,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: synchronises rx, samples mid-bit, presents good bytes with a valid strobe
// and flags low stop bits with a frame_err strobe before waiting out the break.
module uart_rx_frame #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic            CLOCK_50,
    input  logic            Reset,
    uart_rx_frame_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] HALF     = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 hist_q, hist_d;
    logic [1:0]           warm_q, warm_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic                 fall_c;
    logic [CNT_W-1:0]     cnt_inc_c;

    // The history flop only holds a real line sample three clocks after reset;
    // gating on warm_q keeps a line held low across reset release from looking like an edge.
    assign fall_c    = (warm_q == 2'd3) && hist_q && !sync2_q;
    assign cnt_inc_c = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        sync1_d = bus.rx;
        sync2_d = sync1_q;
        hist_d  = sync2_q;
        warm_d  = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;

        unique case (state_q)
            S_IDLE: begin
                if (fall_c) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = sync2_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end
            S_DATA: begin
                if (cnt_q == LAST) begin
                    shift_d[idx_q] = sync2_q;
                    cnt_d          = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end
            S_STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (sync2_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end
            S_BREAK: begin
                if (sync2_q) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 1'b1;
            warm_q  <= '0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
            warm_q  <= warm_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = err_q;
    assign bus.busy      = busy_q;
endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
Serial receiver for the UART link; the far-end counterpart of the transmit controller and shift stage. It samples the incoming line at CLOCK_50 and recovers 8N1 frames: start bit, DATA_BITS data bits LSB first, no parity, one stop bit. Each good byte is presented on a parallel bus with a one-cycle valid strobe. Bad stop bits are flagged with a one-cycle error strobe.

Parameters:
CLKS_PER_BIT, 434, CLOCK_50 cycles per bit period (50 MHz / 115200 baud); must be >= 8.
DATA_BITS, 8, data bits per frame.

Ports:
CLOCK_50  input  1  system clock; all state updates on its rising edge.
Reset  input  1  asynchronous, active-high reset.
rx  input  1  serial line, asynchronous to CLOCK_50, idles high.
data  output  DATA_BITS  last correctly received byte; held until the next good frame.
valid  output  1  one-cycle pulse when data is updated.
frame_err  output  1  one-cycle pulse when the stop bit samples low.
busy  output  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock, CLOCK_50. Reset is asynchronous and active-high.
- Reset values: data = 0, valid = 0, frame_err = 0, busy = 0, state = IDLE, bit counter = 0, baud counter = 0.
- Synchroniser: two-flop synchroniser on rx, followed by one history flop. All three flops reset to 1. All decisions use the synchronised value rx_s.
- Falling-edge detect: previous rx_s = 1 and current rx_s = 0.
- A line held low across reset release must not start a frame.
- Baud counter: width clog2(CLKS_PER_BIT). It clears on every state entry.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: on a falling edge, go to START.
- START: count to HALF = (CLKS_PER_BIT-1)/2 (216 at default).
  - At HALF, if rx_s = 0, go to DATA with bit index 0.
  - At HALF, if rx_s = 1, treat as a glitch: return to IDLE with no strobe.
- DATA: at count CLKS_PER_BIT-1, sample rx_s into shift bit[index], LSB first.
  - After sampling index DATA_BITS-1, go to STOP.
  - Otherwise increment the index and clear the counter.
- STOP: at count CLKS_PER_BIT-1, sample rx_s.
  - If rx_s = 1: load data from the shift register, pulse valid for one cycle, return to IDLE.
  - If rx_s = 0: data unchanged, pulse frame_err for one cycle, go to BREAK.
- BREAK: stay until rx_s = 1, then go to IDLE. A held-low break line yields exactly one frame_err and no further frames.
- Latency: valid asserts on the first clock after the stop-bit sample clock.
  - Sampling falls at mid-bit: HALF + 1 + k*CLKS_PER_BIT cycles after the detected edge, k = 1..DATA_BITS+1.
  - Total is therefore about 9.5 bit times plus 3 synchroniser cycles from the line edge.
- Back-to-back frames: returning to IDLE at mid-stop-bit lets the next start edge be detected with no gap cycle required.
- Strobes: valid and frame_err are mutually exclusive and never high for more than one cycle.
- Reset mid-frame: immediate return to the reset values. The partial frame is discarded.
- An rx edge arriving during START, DATA or STOP is ignored except through the scheduled samples.

Test Plan:
1. After reset, drive frame 0xA5 at 434 clocks/bit -> valid high for exactly 1 cycle, data = 0xA5, frame_err = 0, busy low afterwards.
2. Drive a 100-cycle low glitch with the line otherwise high -> no valid, no frame_err, busy high for about 219 cycles, then IDLE.
3. Drive frame 0x3C with stop bit = 0, line held low 20 bit times -> one frame_err pulse, data keeps its prior value, no valid. Then line high plus frame 0x5A -> data = 0x5A, valid pulse.
4. Drive frames 0x00 and 0xFF back-to-back with no idle gap -> two valid pulses about 4340 cycles apart, data 0x00 then 0xFF.
5. Assert Reset during data bit 4 of a frame -> data = 0, busy = 0 immediately. After release, frame 0x81 -> data = 0x81, valid pulse.
6. Hold rx low through and after Reset release, then raise it -> no frame starts and no strobes. A following frame 0x12 -> data = 0x12.
